uart_xcvr: RTL

UART_XCVR -- requirements
Module: uart_xcvr

---
 rtl/uart_xcvr.sv | 290 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_xcvr.sv
`default_nettype none
// ============================================================================
// Module   : uart_xcvr
// Brief    : UART transmitter and receiver with an RX FIFO and sticky errors.
// Revision : 1.0
// ============================================================================
module uart_xcvr #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        i_sysclk,
    input  logic                        i_reset_n,
    input  logic [DATA_BITS-1:0]        i_tx_data,
    input  logic                        i_tx_valid,
    output logic                        o_tx_ready,
    output logic                        o_tx,
    input  logic                        i_rx,
    output logic [DATA_BITS-1:0]        o_rx_data,
    output logic                        o_rx_valid,
    input  logic                        i_rx_ready,
    output logic [$clog2(FIFO_DEPTH):0] o_rx_count,
    output logic                        o_rx_overrun,
    output logic                        o_rx_frame_err,
    output logic                        o_rx_parity_err,
    input  logic                        i_err_clr
);

    localparam int c_DIV    = CLK_HZ / BAUD;
    localparam int c_CNT_W  = $clog2(STOP_BITS * c_DIV + 1);
    localparam int c_BIT_W  = $clog2(DATA_BITS + 1);
    localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
    localparam int c_CNTF_W = c_PTR_W + 1;

    localparam logic [c_CNT_W-1:0] c_DIV_M1   = c_CNT_W'(c_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_HALF_M1  = c_CNT_W'(c_DIV / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_STOP_M1  = c_CNT_W'(STOP_BITS * c_DIV - 1);
    localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(DATA_BITS - 1);
    localparam logic               c_ODD      = (PARITY == 1);
    localparam logic               c_HAS_PAR  = (PARITY != 0);

    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_START  = 3'd1;
    localparam logic [2:0] c_S_DATA   = 3'd2;
    localparam logic [2:0] c_S_PARITY = 3'd3;
    localparam logic [2:0] c_S_STOP   = 3'd4;

    logic [2:0]           r_tx_state;
    logic [c_CNT_W-1:0]   r_tx_cnt;
    logic [c_BIT_W-1:0]   r_tx_bit;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic                 r_tx_par;
    logic                 r_tx;
    logic                 r_tx_ready;

    // Ready is registered so it stays low through reset and rises one edge later.
    always_ff @(posedge i_sysclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_tx_state <= c_S_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_tx       <= 1'b1;
            r_tx_ready <= 1'b0;
        end else begin
            case (r_tx_state)
                c_S_IDLE: begin
                    r_tx_cnt <= '0;
                    r_tx     <= 1'b1;
                    if (r_tx_ready && i_tx_valid) begin
                        r_tx_shift <= i_tx_data;
                        r_tx_par   <= (^i_tx_data) ^ c_ODD;
                        r_tx       <= 1'b0;
                        r_tx_ready <= 1'b0;
                        r_tx_state <= c_S_START;
                    end else begin
                        r_tx_ready <= 1'b1;
                    end
                end
                c_S_START: begin
                    if (r_tx_cnt == c_DIV_M1) begin
                        r_tx_cnt   <= '0;
                        r_tx_bit   <= '0;
                        r_tx       <= r_tx_shift[0];
                        r_tx_state <= c_S_DATA;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + c_CNT_W'(1);
                    end
                end
                c_S_DATA: begin
                    if (r_tx_cnt == c_DIV_M1) begin
                        r_tx_cnt <= '0;
                        if (r_tx_bit == c_LAST_BIT) begin
                            if (c_HAS_PAR) begin
                                r_tx       <= r_tx_par;
                                r_tx_state <= c_S_PARITY;
                            end else begin
                                r_tx       <= 1'b1;
                                r_tx_state <= c_S_STOP;
                            end
                        end else begin
                            r_tx_bit   <= r_tx_bit + c_BIT_W'(1);
                            r_tx       <= r_tx_shift[1];
                            r_tx_shift <= r_tx_shift >> 1;
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + c_CNT_W'(1);
                    end
                end
                c_S_PARITY: begin
                    if (r_tx_cnt == c_DIV_M1) begin
                        r_tx_cnt   <= '0;
                        r_tx       <= 1'b1;
                        r_tx_state <= c_S_STOP;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + c_CNT_W'(1);
                    end
                end
                c_S_STOP: begin
                    if (r_tx_cnt == c_STOP_M1) begin
                        r_tx_cnt   <= '0;
                        r_tx_ready <= 1'b1;
                        r_tx_state <= c_S_IDLE;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + c_CNT_W'(1);
                    end
                end
                default: begin
                    r_tx       <= 1'b1;
                    r_tx_state <= c_S_IDLE;
                end
            endcase
        end
    end

    assign o_tx       = r_tx;
    assign o_tx_ready = r_tx_ready;

    logic                 r_rx_s1;
    logic                 r_rx_s2;
    logic [2:0]           r_rx_state;
    logic [c_CNT_W-1:0]   r_rx_cnt;
    logic [c_BIT_W-1:0]   r_rx_bit;
    logic [DATA_BITS-1:0] r_rx_shift;
    logic                 r_rx_par_bad;

    always_ff @(posedge i_sysclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
        end else begin
            r_rx_s1 <= i_rx;
            r_rx_s2 <= r_rx_s1;
        end
    end

    // Only the first stop bit is sampled; the line is idle-high for any extra stop bits.
    always_ff @(posedge i_sysclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rx_state   <= c_S_IDLE;
            r_rx_cnt     <= '0;
            r_rx_bit     <= '0;
            r_rx_shift   <= '0;
            r_rx_par_bad <= 1'b0;
        end else begin
            case (r_rx_state)
                c_S_IDLE: begin
                    r_rx_cnt <= '0;
                    if (!r_rx_s2) begin
                        r_rx_state <= c_S_START;
                    end
                end
                c_S_START: begin
                    if (r_rx_cnt == c_HALF_M1) begin
                        r_rx_cnt     <= '0;
                        r_rx_bit     <= '0;
                        r_rx_par_bad <= 1'b0;
                        r_rx_state   <= r_rx_s2 ? c_S_IDLE : c_S_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + c_CNT_W'(1);
                    end
                end
                c_S_DATA: begin
                    if (r_rx_cnt == c_DIV_M1) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {r_rx_s2, r_rx_shift[DATA_BITS-1:1]};
                        if (r_rx_bit == c_LAST_BIT) begin
                            r_rx_state <= c_HAS_PAR ? c_S_PARITY : c_S_STOP;
                        end else begin
                            r_rx_bit <= r_rx_bit + c_BIT_W'(1);
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + c_CNT_W'(1);
                    end
                end
                c_S_PARITY: begin
                    if (r_rx_cnt == c_DIV_M1) begin
                        r_rx_cnt     <= '0;
                        r_rx_par_bad <= r_rx_s2 != ((^r_rx_shift) ^ c_ODD);
                        r_rx_state   <= c_S_STOP;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + c_CNT_W'(1);
                    end
                end
                c_S_STOP: begin
                    if (r_rx_cnt == c_DIV_M1) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= c_S_IDLE;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + c_CNT_W'(1);
                    end
                end
                default: r_rx_state <= c_S_IDLE;
            endcase
        end
    end

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNTF_W-1:0]  r_count;
    logic                 r_ovr;
    logic                 r_frm;
    logic                 r_par;

    logic w_rx_done;
    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_rx_done = (r_rx_state == c_S_STOP) && (r_rx_cnt == c_DIV_M1);
    assign w_full    = (r_count == c_CNTF_W'(FIFO_DEPTH));
    assign w_pop     = (r_count != '0) && i_rx_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_push    = w_rx_done && (!w_full || w_pop);

    always_ff @(posedge i_sysclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_rx_shift;
        end
    end

    always_ff @(posedge i_sysclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNTF_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_CNTF_W'(1);
            end
        end
    end

    always_ff @(posedge i_sysclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_ovr <= 1'b0;
            r_frm <= 1'b0;
            r_par <= 1'b0;
        end else begin
            if (w_rx_done && w_full && !w_pop) r_ovr <= 1'b1;
            else if (i_err_clr)                r_ovr <= 1'b0;
            if (w_rx_done && !r_rx_s2)         r_frm <= 1'b1;
            else if (i_err_clr)                r_frm <= 1'b0;
            if (w_rx_done && r_rx_par_bad)     r_par <= 1'b1;
            else if (i_err_clr)                r_par <= 1'b0;
        end
    end

    assign o_rx_valid      = (r_count != '0);
    assign o_rx_data       = o_rx_valid ? r_mem[r_rd_ptr] : '0;
    assign o_rx_count      = r_count;
    assign o_rx_overrun    = r_ovr;
    assign o_rx_frame_err  = r_frm;
    assign o_rx_parity_err = r_par;

endmodule
`default_nettype wire
